// File: rtl/demux_2param_buf.sv
// rtl/demux_2param_buf.sv - registered 1-to-4 demultiplexer with per-destination hold slots
module demux_2param_buf #(
  parameter int N  = 4,
  parameter int X  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [X-1:0]  in_data,
  input  logic [1:0]    s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [X-1:0]  A,
  output logic [X-1:0]  B,
  output logic [X-1:0]  C,
  output logic [X-1:0]  D,
  output logic          a_valid,
  output logic          b_valid,
  output logic          c_valid,
  output logic          d_valid,
  input  logic          a_ready,
  input  logic          b_ready,
  input  logic          c_ready,
  input  logic          d_ready,
  output logic [CW-1:0] drop_cnt
);

  logic [3:0]    full_q, full_d;
  logic [X-1:0]  slot_q [4];
  logic [X-1:0]  slot_d [4];
  logic [CW-1:0] drop_q, drop_d;
  logic [3:0]    k_ready;
  logic          s_invalid;
  logic          accept;

  assign k_ready   = {d_ready, c_ready, b_ready, a_ready};
  assign s_invalid = (32'(s) >= 32'(N));
  assign accept    = in_valid && in_ready;

  // Offer acceptance: unpopulated destinations always sink, others need a free or draining slot
  always_comb begin
    in_ready = 1'b1;
    if (!s_invalid) begin
      in_ready = !full_q[s] || k_ready[s];
    end
  end

  // Next state: drain first, then a fill overrides so drain+fill keeps the slot full
  always_comb begin
    full_d = full_q & ~k_ready;
    drop_d = drop_q;
    for (int k = 0; k < 4; k++) begin
      slot_d[k] = slot_q[k];
      if (accept && (s == k[1:0]) && (k < N)) begin
        full_d[k] = 1'b1;
        slot_d[k] = in_data;
      end
    end
    if (accept && s_invalid && (drop_q != {CW{1'b1}})) begin
      drop_d = drop_q + CW'(1);
    end
  end

  // State registers; reset clears slots, flags and the drop counter without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      drop_q <= '0;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      drop_q <= drop_d;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign A        = slot_q[0];
  assign B        = slot_q[1];
  assign C        = slot_q[2];
  assign D        = slot_q[3];
  assign a_valid  = full_q[0];
  assign b_valid  = full_q[1];
  assign c_valid  = full_q[2];
  assign d_valid  = full_q[3];
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_2param_buf.sv
// tb/tb_demux_2param_buf.sv - self-checking bench for demux_2param_buf
module tb_demux_2param_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] t_data  [2];
  logic [1:0]  t_s     [2];
  logic        t_valid [2];
  logic [3:0]  t_rdy   [2];

  wire        rdy0, rdy1;
  wire [15:0] a0, b0, c0, d0, a1, b1, c1, d1;
  wire [3:0]  v0, v1;
  wire [7:0]  drop0;
  wire [1:0]  drop1;

  int n_checks = 0;
  int n_errors = 0;

  demux_2param_buf #(.N(4), .X(16), .CW(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data[0]), .s(t_s[0]),
    .in_valid(t_valid[0]), .in_ready(rdy0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .a_valid(v0[0]), .b_valid(v0[1]), .c_valid(v0[2]), .d_valid(v0[3]),
    .a_ready(t_rdy[0][0]), .b_ready(t_rdy[0][1]), .c_ready(t_rdy[0][2]), .d_ready(t_rdy[0][3]),
    .drop_cnt(drop0)
  );

  demux_2param_buf #(.N(3), .X(16), .CW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data[1]), .s(t_s[1]),
    .in_valid(t_valid[1]), .in_ready(rdy1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .a_valid(v1[0]), .b_valid(v1[1]), .c_valid(v1[2]), .d_valid(v1[3]),
    .a_ready(t_rdy[1][0]), .b_ready(t_rdy[1][1]), .c_ready(t_rdy[1][2]), .d_ready(t_rdy[1][3]),
    .drop_cnt(drop1)
  );

  function automatic logic f_rdy(input int u);
    return (u == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic f_val(input int u, input int k);
    return (u == 0) ? v0[k[1:0]] : v1[k[1:0]];
  endfunction

  function automatic logic [15:0] f_out(input int u, input int k);
    logic [15:0] r;
    case (k)
      0:       r = (u == 0) ? a0 : a1;
      1:       r = (u == 0) ? b0 : b1;
      2:       r = (u == 0) ? c0 : c1;
      default: r = (u == 0) ? d0 : d1;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] f_drop(input int u);
    return (u == 0) ? drop0 : {6'b0, drop1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic v, input logic [1:0] ss,
                       input logic [15:0] d, input logic [3:0] r);
    t_valid[u] = v;
    t_s[u]     = ss;
    t_data[u]  = d;
    t_rdy[u]   = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) drive(u, 1'b0, 2'd0, 16'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Producer rule: a stalled offer must hold s/in_data until accepted
  logic        st_q  [2];
  logic [17:0] off_q [2];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_n && st_q[u] && t_valid[u])
        assert ({t_s[u], t_data[u]} == off_q[u])
          else $error("FAIL producer_stable unit %0d", u);
      st_q[u]  <= rst_n && t_valid[u] && !f_rdy(u);
      off_q[u] <= {t_s[u], t_data[u]};
    end
  end

  // Scoreboard run: each populated destination holds at most one pending word, in order
  task automatic run_random(input int u, input int n, input int cycles);
    logic [15:0] q [4][$];
    int          drops, dmax, acc, dlv;
    logic        stalled, exp_v, exp_rdy;
    logic        v;
    logic [1:0]  ss;
    logic [15:0] d;
    logic [3:0]  r;
    drops = 0; acc = 0; dlv = 0; stalled = 1'b0;
    dmax = (u == 0) ? 255 : 3;
    v = 1'b0; ss = 2'd0; d = 16'h0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      if (!stalled) begin
        v  = ($urandom_range(0, 3) != 0);
        ss = 2'($urandom_range(0, 3));
        d  = 16'($urandom);
      end
      r = 4'($urandom_range(0, 15));
      drive(u, v, ss, d, r);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp_v = (k < n) && (q[k].size() != 0);
        check("rand_valid", {31'b0, f_val(u, k)}, {31'b0, exp_v});
        if (exp_v) check("rand_data", {16'b0, f_out(u, k)}, {16'b0, q[k][0]});
        else if (k >= n) check("rand_unpop_data", {16'b0, f_out(u, k)}, 32'h0);
      end
      exp_rdy = (int'(ss) >= n) || (q[ss].size() == 0) || r[ss];
      check("rand_in_ready", {31'b0, f_rdy(u)}, {31'b0, exp_rdy});
      check("rand_drop_cnt", {24'b0, f_drop(u)}, drops);
      for (int k = 0; k < n; k++) begin
        if (q[k].size() != 0 && r[k]) begin
          void'(q[k].pop_front());
          dlv++;
        end
      end
      if (v && exp_rdy) begin
        if (int'(ss) >= n) begin
          if (drops < dmax) drops++;
        end else begin
          q[ss].push_back(d);
          acc++;
        end
      end
      stalled = v && !exp_rdy;
      @(posedge clk);
      #1;
    end
    drive(u, 1'b0, 2'd0, 16'h0, 4'h0);
    check("rand_no_loss", acc - dlv, q[0].size() + q[1].size() + q[2].size() + q[3].size());
  endtask

  initial begin
    logic [15:0] vals [3];
    vals[0] = 16'hAAAA; vals[1] = 16'h1111; vals[2] = 16'h2222;

    do_reset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) begin
        check("reset_data", {16'b0, f_out(u, k)}, 32'h0);
        check("reset_valid", {31'b0, f_val(u, k)}, 32'h0);
      end
      check("reset_in_ready", {31'b0, f_rdy(u)}, 32'h1);
      check("reset_drop", {24'b0, f_drop(u)}, 32'h0);
    end

    // Route one word to B
    drive(0, 1'b1, 2'd1, 16'hBBBB, 4'h0);
    #1 check("t1_in_ready", {31'b0, rdy0}, 32'h1);
    tick();
    drive(0, 1'b0, 2'd1, 16'hBBBB, 4'h0);
    check("t1_B", {16'b0, b0}, 32'hBBBB);
    check("t1_valids", {28'b0, v0}, 32'h2);
    check("t1_A", {16'b0, a0}, 32'h0);
    check("t1_C", {16'b0, c0}, 32'h0);
    check("t1_D", {16'b0, d0}, 32'h0);

    // Stall on full B, then release, then route to C while B is stalled
    drive(0, 1'b1, 2'd1, 16'hCCCC, 4'h0);
    #1 check("t2_stall_ready", {31'b0, rdy0}, 32'h0);
    tick();
    check("t2_B_held", {16'b0, b0}, 32'hBBBB);
    drive(0, 1'b1, 2'd1, 16'hCCCC, 4'h2);
    #1 check("t2_release_ready", {31'b0, rdy0}, 32'h1);
    tick();
    check("t2_B_new", {16'b0, b0}, 32'hCCCC);
    check("t2_b_valid", {31'b0, v0[1]}, 32'h1);
    drive(0, 1'b1, 2'd2, 16'hDDDD, 4'h0);
    #1 check("t2_C_ready", {31'b0, rdy0}, 32'h1);
    tick();
    check("t2_C", {16'b0, c0}, 32'hDDDD);
    check("t2_B_keep", {16'b0, b0}, 32'hCCCC);
    check("t2_valids", {28'b0, v0}, 32'h6);
    drive(0, 1'b0, 2'd0, 16'h0, 4'hF);
    tick();
    check("t2_drained", {28'b0, v0}, 32'h0);
    check("t2_B_hold_after_drain", {16'b0, b0}, 32'hCCCC);

    // Back-to-back stream into A
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 2'd0, vals[i], 4'h1);
      #1 check("t3_in_ready", {31'b0, rdy0}, 32'h1);
      tick();
      check("t3_A", {16'b0, a0}, {16'b0, vals[i]});
      check("t3_a_valid", {31'b0, v0[0]}, 32'h1);
    end
    drive(0, 1'b0, 2'd0, 16'h0, 4'h1);
    tick();
    check("t3_a_drained", {31'b0, v0[0]}, 32'h0);

    // Drops on N=3 / CW=2 unit, saturating at 3
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 2'd3, 16'hFFFF, 4'h0);
      #1 check("t4_in_ready", {31'b0, rdy1}, 32'h1);
      tick();
      check("t4_drop", {30'b0, drop1}, (i < 3) ? i + 1 : 3);
      check("t4_d_valid", {31'b0, v1[3]}, 32'h0);
      check("t4_D", {16'b0, d1}, 32'h0);
    end
    drive(1, 1'b0, 2'd0, 16'h0, 4'h0);

    // Asynchronous reset between edges
    drive(0, 1'b1, 2'd0, 16'h1234, 4'h0);
    tick();
    drive(0, 1'b1, 2'd2, 16'h5678, 4'h0);
    tick();
    drive(0, 1'b0, 2'd0, 16'h0, 4'h0);
    check("t5_A_fill", {16'b0, a0}, 32'h1234);
    check("t5_C_fill", {16'b0, c0}, 32'h5678);
    #2 rst_n = 1'b0;
    #1;
    check("t5_A_async", {16'b0, a0}, 32'h0);
    check("t5_C_async", {16'b0, c0}, 32'h0);
    check("t5_valids_async", {28'b0, v0}, 32'h0);
    check("t5_drop_async", {30'b0, drop1}, 32'h0);
    #2 rst_n = 1'b1;
    drive(0, 1'b1, 2'd0, 16'h9ABC, 4'h0);
    #1 check("t5_ready", {31'b0, rdy0}, 32'h1);
    tick();
    drive(0, 1'b0, 2'd0, 16'h0, 4'h0);
    check("t5_A_after", {16'b0, a0}, 32'h9ABC);
    check("t5_valids_after", {28'b0, v0}, 32'h1);

    run_random(0, 4, 10000);
    run_random(1, 3, 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_2param_buf.md
Name: demux_2param_buf

Overview:
- Registered 1-to-4 demultiplexer for the datapath: the write-side counterpart of the parameterized 4:1 output mux.
- Accepts one X-bit word per cycle through a valid/ready handshake and steers it, by the 2-bit select s, into one of up to four per-destination hold registers.
- Each hold register drives its own output with its own valid/ready handshake.
- Words addressed to an unpopulated destination are accepted, discarded and counted.

Parameters:
- N, 4, number of populated destinations (1..4); destination index = s, and s >= N is invalid.
- X, 16, data width in bits.
- CW, 8, width of the drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  X  word to route.
- s  input  2  destination select: 00->A, 01->B, 10->C, 11->D.
- in_valid  input  1  in_data/s valid.
- in_ready  output  1  block can accept this cycle.
- A, B, C, D  output  X each  hold-register contents per destination.
- a_valid, b_valid, c_valid, d_valid  output  1 each  destination register holds an unconsumed word.
- a_ready, b_ready, c_ready, d_ready  input  1 each  consumer takes the word this cycle.
- drop_cnt  output  CW  saturating count of words sent to invalid destinations.

Behaviour:
- Reset:
  - rst_n low clears immediately, without waiting for clk: A..D = 0, all *_valid = 0, drop_cnt = 0.
  - In-flight words are lost. No handshake completes in a cycle where rst_n is low.
  - in_ready is 1 out of reset, since all slots are empty.
- Slot state: each destination k (k < N) has a full flag. k_valid = full[k].
  - Drain: k_valid && k_ready clears full[k] at the edge.
  - Fill: an accept targeting k sets full[k] and loads in_data into the k register.
  - Simultaneous drain and fill of the same slot in one cycle: the new word is loaded and full stays 1, giving back-to-back throughput of 1 word/cycle per destination.
- in_ready is combinational from s, full[] and *_ready:
  - 1 if s >= N;
  - otherwise 1 if !full[s] || k_ready[s].
  - It never depends on in_valid.
- Accept = in_valid && in_ready.
- Latency: a word accepted at edge t appears on the destination output with valid = 1 after edge t, i.e. one cycle later. There is no combinational path from in_data to A..D.
- Hold: an output register changes only on a fill. After a drain the data stays at its last value with valid = 0. Unpopulated outputs (index >= N) are constant 0 with valid 0.
- Invalid destination:
  - An accept with s >= N does not touch any slot and increments drop_cnt by 1.
  - drop_cnt saturates at 2^CW-1 and does not wrap. It is cleared only by reset.
- Independence: a full, stalled slot blocks only words addressed to it. Words for other free slots keep flowing. There is no head-of-line buffering beyond the single input word under offer.
- Producer rule: in_data and s must stay stable while in_valid = 1 and in_ready = 0. A bench assertion flags any violation.
- N = 1 degenerates to a single registered stage on A: s = 00 goes to A, and every other s is dropped and counted.

Test Plan:
1. Reset, then in_valid = 1, s = 01, in_data = 16'hBBBB, b_ready = 0 -> in_ready = 1; next cycle B = BBBB, b_valid = 1, A/C/D unchanged at 0000 with valid 0.
2. With B full and b_ready = 0, offer s = 01, in_data = CCCC -> in_ready = 0 and B stays BBBB. Raise b_ready -> same cycle in_ready = 1; next cycle B = CCCC, b_valid = 1. Also offer s = 10, in_data = DDDD while B is stalled -> accepted, C = DDDD.
3. Stream AAAA, 1111, 2222 to s = 00 with a_ready = 1 every cycle -> A shows each value on consecutive cycles, a_valid stays 1, in_ready stays 1.
4. N = 3: offer s = 11, in_data = FFFF for 3 cycles -> in_ready = 1, drop_cnt = 3, d_valid = 0, D = 0000. With CW = 2, 5 drops -> drop_cnt = 3 (saturated).
5. Fill A = 1234 and C = 5678, then pulse rst_n low between clock edges -> outputs go to 0 and valids to 0 immediately. After release, offer s = 00, in_data = 9ABC -> A = 9ABC one cycle later.
6. Random valid/ready/s over 10k cycles vs a scoreboard model -> per-destination word order preserved, no loss or duplication, drop_cnt matches the count of s >= N accepts.
